// File: rtl/mask_gen_if.sv
// Handshake bundle between an activation producer, mask_gen and the downstream mask consumer.
// Both sides use valid/ready: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
interface mask_gen_if #(
  parameter int C = 6
);
  localparam int N  = 32;
  localparam int OW = $clog2(C + 1);

  logic                        in_valid;
  logic                        in_ready;
  logic [N-1:0]                in_data;
  logic [N-2:0]                thr;
  logic                        out_valid;
  logic                        out_ready;
  logic [0:0][0:C-1][N-1:0]    m;
  logic [OW-1:0]               ones;
  logic                        fsm_state;

  modport master (
    output in_valid, in_data, thr, out_ready,
    input  in_ready, out_valid, m, ones, fsm_state
  );

  modport slave (
    input  in_valid, in_data, thr, out_ready,
    output in_ready, out_valid, m, ones, fsm_state
  );
endinterface

// File: rtl/mask_gen.sv
// Collects C sign/threshold decisions into a one-row fixed-point mask vector
// and holds it until downstream accepts it.
module mask_gen #(
  parameter int C = 6,
  parameter int F = 17
) (
  input  logic        clk,
  input  logic        rst,
  mask_gen_if.slave   bus
);
  localparam int N  = 32;
  localparam int IW = (C > 1) ? $clog2(C) : 1;
  localparam int OW = $clog2(C + 1);

  localparam logic [0:0]    S_FILL = 1'b0;
  localparam logic [0:0]    S_HOLD = 1'b1;
  localparam logic [N-1:0]  ONE    = {{(N-1){1'b0}}, 1'b1} << F;
  localparam logic [IW-1:0] LAST   = IW'(C - 1);

  logic [0:0]    state;
  logic [IW-1:0] idx;
  logic          hit;

  // Strictly greater than thr, positive sign only: +0 and -0 never pass.
  assign hit = !bus.in_data[N-1] && (bus.in_data[N-2:0] > bus.thr);

  assign bus.in_ready  = (state == S_FILL) && !rst;
  assign bus.fsm_state = state[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_FILL;
      idx           <= '0;
      bus.m         <= '0;
      bus.ones      <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      case (state)
        S_FILL: begin
          if (bus.in_valid) begin
            bus.m[0][idx] <= hit ? ONE : '0;
            if (hit) begin
              bus.ones <= bus.ones + OW'(1);
            end
            if (idx == LAST) begin
              state         <= S_HOLD;
              bus.out_valid <= 1'b1;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        S_HOLD: begin
          // Old entries are left in place; each is overwritten as the next vector fills.
          if (bus.out_ready) begin
            state         <= S_FILL;
            idx           <= '0;
            bus.ones      <= '0;
            bus.out_valid <= 1'b0;
          end
        end
        default: begin
          state <= S_FILL;
          idx   <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mask_gen.sv
// Bench for mask_gen: queue-based reference of accepted decisions, per-cycle compare,
// directed vectors with literal expectations, then a randomized soak.
module tb_mask_gen;
  localparam int C = 6;
  localparam int F = 17;
  localparam int N = 32;
  localparam logic [N-1:0] ONE = 32'h0002_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mask_gen_if #(.C(C)) bus();
  mask_gen #(.C(C), .F(F)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  logic [N-1:0] exp_q[$];
  bit           holding = 1'b0;

  logic [N-1:0] vec[C];
  logic [N-1:0] lit[C];

  function automatic logic [N-1:0] ref_mask(logic [N-1:0] d, logic [N-2:0] t);
    return (d[N-1] == 1'b0 && d[N-2:0] > t) ? ONE : '0;
  endfunction

  task automatic check(string name, logic [N-1:0] act, logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: a vector is the list of decisions for the last C accepted elements.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      holding = 1'b0;
    end else if (!holding) begin
      if (bus.in_valid) begin
        exp_q.push_back(ref_mask(bus.in_data, bus.thr));
        if (exp_q.size() == C) holding = 1'b1;
      end
    end else if (bus.out_ready) begin
      holding = 1'b0;
      exp_q.delete();
    end
  end

  always @(negedge clk) begin
    int cnt;
    check("in_ready", {31'b0, bus.in_ready}, {31'b0, (!holding && !rst)});
    check("out_valid", {31'b0, bus.out_valid}, {31'b0, holding});
    if (holding) begin
      cnt = 0;
      for (int k = 0; k < C; k++) begin
        check($sformatf("m%0d", k), bus.m[0][k], exp_q[k]);
        if (exp_q[k] == ONE) cnt++;
      end
      check("ones", {29'b0, bus.ones}, N'(cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [N-1:0] d, logic [N-2:0] t);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.thr      = t;
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = $urandom;
  endtask

  task automatic send_vec(int max_gap, logic [N-2:0] t);
    for (int k = 0; k < C; k++) begin
      repeat ($urandom_range(max_gap, 0)) begin
        bus.in_data = $urandom;
        tick();
      end
      send(vec[k], t);
    end
  endtask

  task automatic check_lit(string tag, int exp_ones);
    check({tag, "_out_valid"}, {31'b0, bus.out_valid}, 32'd1);
    for (int k = 0; k < C; k++)
      check($sformatf("%s_m%0d", tag, k), bus.m[0][k], lit[k]);
    check({tag, "_ones"}, {29'b0, bus.ones}, N'(exp_ones));
  endtask

  initial begin
    logic [N-2:0] mag;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.thr       = '0;
    bus.out_ready = 1'b0;

    // Reset
    repeat (3) begin
      tick();
      check("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
    end
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("post_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("post_rst_ones", {29'b0, bus.ones}, 32'd0);
    for (int k = 0; k < C; k++)
      check($sformatf("post_rst_m%0d", k), bus.m[0][k], 32'd0);

    // Basic vector, back-to-back
    bus.out_ready = 1'b1;
    vec = '{32'h00ffffff, 32'h00000000, 32'h80056fc2, 32'h00056fc2, 32'h0006487e, 32'h80000000};
    lit = '{ONE, 32'h0, 32'h0, ONE, ONE, 32'h0};
    send_vec(0, '0);
    check_lit("basic", 3);
    tick();
    check("basic_ov_fall", {31'b0, bus.out_valid}, 32'd0);
    check("basic_in_ready", {31'b0, bus.in_ready}, 32'd1);

    // Threshold boundary
    vec = '{32'h00056fc2, 32'h00056fc3, 32'h0, 32'h0, 32'h0, 32'h0};
    lit = '{32'h0, ONE, 32'h0, 32'h0, 32'h0, 32'h0};
    send_vec(0, 31'h56fc2);
    check_lit("thr", 1);
    tick();

    // Backpressure
    bus.out_ready = 1'b0;
    vec = '{32'h00ffffff, 32'h00000000, 32'h80056fc2, 32'h00056fc2, 32'h0006487e, 32'h80000000};
    lit = '{ONE, 32'h0, 32'h0, ONE, ONE, 32'h0};
    send_vec(0, '0);
    check_lit("bp_start", 3);
    repeat (10) begin
      bus.in_valid = 1'b1;
      bus.in_data  = $urandom;
      tick();
      check("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
    end
    check_lit("bp_end", 3);
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    check("bp_exit_in_ready", {31'b0, bus.in_ready}, 32'd1);
    vec = '{32'h00056fc2, 32'h00056fc3, 32'h0, 32'h0, 32'h0, 32'h0};
    lit = '{32'h0, ONE, 32'h0, 32'h0, 32'h0, 32'h0};
    send_vec(0, 31'h56fc2);
    check_lit("bp_next", 1);
    tick();

    // Stalled input
    vec = '{32'h00ffffff, 32'h00000000, 32'h80056fc2, 32'h00056fc2, 32'h0006487e, 32'h80000000};
    lit = '{ONE, 32'h0, 32'h0, ONE, ONE, 32'h0};
    send_vec(4, '0);
    check_lit("stall", 3);
    tick();

    // Reset mid-fill
    repeat (3) send(32'h7fffffff, '0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < C; k++) begin
      vec[k] = 32'h0006487e;
      lit[k] = ONE;
    end
    send_vec(0, '0);
    check_lit("rst_mid", 6);
    tick();

    // Randomized soak
    repeat (800) begin
      bus.thr       = 31'($urandom_range(1000, 0));
      mag           = (($urandom_range(3, 0)) == 0) ? 31'($urandom) :
                      bus.thr + 31'($urandom_range(2, 0)) - 31'd1;
      bus.in_data   = {1'($urandom_range(1, 0)), mag};
      bus.in_valid  = 1'($urandom_range(1, 0));
      bus.out_ready = ($urandom_range(3, 0) != 0);
      rst           = ($urandom_range(99, 0) == 0);
      tick();
    end
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
